// File: rtl/mem_stage_wait.sv
// MEM stage with word data memory, self-timed wait states and address fault flag.
// Define MEM_STAGE_BYTE_EN to add byte loads/stores through mem_byte_in.
module mem_stage_wait #(
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 64,
   parameter int BASE_ADDR = 1024,
   parameter int LAT       = 2,
   parameter int DEST_W    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_en_in,
   input  logic              mem_r_en_in,
   input  logic              mem_w_en_in,
   input  logic [DATA_W-1:0] alu_res_in,
   input  logic [DATA_W-1:0] val_rm,
   input  logic [DEST_W-1:0] dest_in,
`ifdef MEM_STAGE_BYTE_EN
   input  logic              mem_byte_in,
`endif
   output logic              wb_en_out,
   output logic              mem_r_en_out,
   output logic [DATA_W-1:0] alu_res_out,
   output logic [DEST_W-1:0] dest_out,
   output logic [DATA_W-1:0] mem_out,
   output logic              ready,
   output logic              mem_err
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = (LAT > 0) ? $clog2(LAT + 1) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'((LAT > 0) ? LAT - 1 : 0);
   localparam logic [DATA_W-1:0] BASE = DATA_W'(BASE_ADDR);
   localparam logic [DATA_W-1:0] SPAN = DATA_W'(4 * DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DATA_W-1:0] out_q, out_d;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              req, is_st, is_ld, byte_acc;
   logic [DATA_W-1:0] off;
   logic [AW-1:0]     idx;
   logic [1:0]        lane;
   logic [4:0]        sh;
   logic              fault, done, cap, commit;
   logic [DATA_W-1:0] rd_word, rd_byte, rd_data;
   logic [DATA_W-1:0] mask, wr_word;

   assign wb_en_out    = wb_en_in;
   assign mem_r_en_out = mem_r_en_in;
   assign alu_res_out  = alu_res_in;
   assign dest_out     = dest_in;
   assign mem_out      = out_q;

   assign req   = mem_r_en_in | mem_w_en_in;
   assign is_st = mem_w_en_in;
   assign is_ld = mem_r_en_in & ~mem_w_en_in;

`ifdef MEM_STAGE_BYTE_EN
   assign byte_acc = mem_byte_in;
`else
   assign byte_acc = 1'b0;
`endif

   assign off  = alu_res_in - BASE;
   assign idx  = off[AW+1:2];
   assign lane = alu_res_in[1:0];
   assign sh   = {lane, 3'b000};

   // both enables high is reported as a faulting store
   assign fault = (alu_res_in < BASE)
                | (off >= SPAN)
                | (~byte_acc & (lane != 2'b00))
                | (mem_r_en_in & mem_w_en_in);

   assign rd_word = mem[idx];
   assign rd_byte = {{(DATA_W-8){1'b0}}, 8'(rd_word >> sh)};
   assign rd_data = fault    ? '0 :
                    byte_acc ? rd_byte : rd_word;

   assign mask    = DATA_W'(8'hFF) << sh;
   assign wr_word = byte_acc
                  ? ((rd_word & ~mask) | (DATA_W'(val_rm[7:0]) << sh))
                  : val_rm;

   // zero-wait build completes the access in the request cycle
   assign done   = (LAT == 0) ? req : (state_q == S_DONE);
   assign cap    = (LAT == 0) ? (req & is_ld)
                 : ((state_q == S_WAIT) & (cnt_q == '0) & is_ld);
   assign commit = done & is_st & ~fault;
   assign mem_err = done & fault;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ready   = 1'b1;
      unique case (state_q)
         S_IDLE: begin
            if (req && (LAT > 0)) begin
               ready   = 1'b0;
               cnt_d   = CNT_INIT;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            ready = 1'b0;
            if (cnt_q == '0) state_d = S_DONE;
            else cnt_d = cnt_q - CW'(1);
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      out_d = out_q;
      if (cap) out_d = rd_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
      end
   end

   // storage is never cleared; reset forces IDLE so no DONE-cycle write survives it
   always_ff @(posedge clk) begin
      if (commit) mem[idx] <= wr_word;
   end

endmodule

// File: tb/tb_mem_stage_wait.sv
// Scoreboard bench for mem_stage_wait: three instances with LAT=2, LAT=0, LAT=3.
// Byte-lane scenario runs only when MEM_STAGE_BYTE_EN is defined.
module tb_mem_stage_wait;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        wb_en, r_en, w_en, byte_en;
   logic [31:0] addr, wdata;
   logic [3:0]  dest;
   int          sel;

   logic        ready_v [3];
   logic        err_v   [3];
   logic        wb_o_v  [3];
   logic        rd_o_v  [3];
   logic [31:0] out_v   [3];
   logic [31:0] alu_o_v [3];
   logic [3:0]  dest_o_v[3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      mem_stage_wait #(
         .LAT((g == 0) ? 2 : ((g == 1) ? 0 : 3))
      ) u_dut (
         .clk         (clk),
         .rst         (rst),
         .wb_en_in    (wb_en),
         .mem_r_en_in (r_en & (sel == g)),
         .mem_w_en_in (w_en & (sel == g)),
         .alu_res_in  (addr),
         .val_rm      (wdata),
         .dest_in     (dest),
`ifdef MEM_STAGE_BYTE_EN
         .mem_byte_in (byte_en),
`endif
         .wb_en_out   (wb_o_v[g]),
         .mem_r_en_out(rd_o_v[g]),
         .alu_res_out (alu_o_v[g]),
         .dest_out    (dest_o_v[g]),
         .mem_out     (out_v[g]),
         .ready       (ready_v[g]),
         .mem_err     (err_v[g])
      );
   end

   typedef struct {
      logic [31:0] out;
      logic        err;
      int          stall;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mdl_mem[int];
   logic [31:0] last_out[3];
   int          pass_cnt = 0;
   int          total    = 0;

   function automatic int lat_of(input int d);
      return (d == 0) ? 2 : ((d == 1) ? 0 : 3);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) last_out[i] = 32'h0;
   endtask

   // at entry: just after a posedge; at exit: just after a posedge, enables low
   task automatic access(input int d, input logic r, input logic w,
                         input logic b, input logic [31:0] a,
                         input logic [31:0] wd, input string nm);
      exp_t        e;
      int          st;
      int unsigned ua;
      int          key;
      int          ln;
      logic        bad;
      logic [31:0] wv;
      ua  = a;
      ln  = int'(ua % 4);
      bad = (ua < 1024) || (ua >= 1280) || (!b && ln != 0) || (r && w);
      key = d * 65536 + int'((ua - 1024) / 4);
      e.err   = bad;
      e.stall = (lat_of(d) == 0) ? 0 : lat_of(d) + 1;
      if (w) begin
         if (!bad) begin
            if (b) begin
               wv = mdl_mem[key];
               wv[8*ln +: 8] = wd[7:0];
               mdl_mem[key] = wv;
            end else begin
               mdl_mem[key] = wd;
            end
         end
         e.out = last_out[d];
      end else begin
         if (bad) e.out = 32'h0;
         else begin
            wv = mdl_mem[key];
            e.out = b ? ((wv >> (8 * ln)) & 32'hFF) : wv;
         end
         last_out[d] = e.out;
      end
      sb.push_back(e);
      sel = d; r_en = r; w_en = w; byte_en = b; addr = a; wdata = wd;
      st = 0;
      @(negedge clk);
      while (!ready_v[d] && st < 20) begin
         st++;
         @(negedge clk);
      end
      e = sb.pop_front();
      total++;
      if (st !== e.stall)
         $display("FAIL %s stall: got %0d want %0d", nm, st, e.stall);
      else pass_cnt++;
      total++;
      if (err_v[d] !== e.err)
         $display("FAIL %s mem_err: got %b want %b", nm, err_v[d], e.err);
      else pass_cnt++;
      @(posedge clk);
      #1;
      total++;
      if (out_v[d] !== e.out)
         $display("FAIL %s mem_out: got %h want %h", nm, out_v[d], e.out);
      else pass_cnt++;
      r_en = 1'b0; w_en = 1'b0; byte_en = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (out_v[i] !== 32'h0)
            $display("FAIL reset_out[%0d]: got %h want 0", i, out_v[i]);
         else pass_cnt++;
         total++;
         if (ready_v[i] !== 1'b1)
            $display("FAIL reset_ready[%0d]: got %b want 1", i, ready_v[i]);
         else pass_cnt++;
         total++;
         if (err_v[i] !== 1'b0)
            $display("FAIL reset_err[%0d]: got %b want 0", i, err_v[i]);
         else pass_cnt++;
      end
      rst = 1'b1;
   endtask

   task automatic test_passthru();
      sel = 0; wb_en = 1'b1; addr = 32'h0000_1234; dest = 4'hA;
      #1;
      total++;
      if (alu_o_v[0] !== 32'h0000_1234)
         $display("FAIL pass_alu: got %h want 00001234", alu_o_v[0]);
      else pass_cnt++;
      total++;
      if (dest_o_v[0] !== 4'hA)
         $display("FAIL pass_dest: got %h want a", dest_o_v[0]);
      else pass_cnt++;
      total++;
      if (wb_o_v[0] !== 1'b1 || rd_o_v[0] !== 1'b0)
         $display("FAIL pass_en: got wb=%b rd=%b want wb=1 rd=0",
                  wb_o_v[0], rd_o_v[0]);
      else pass_cnt++;
      wb_en = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_lat2();
      access(0, 1'b0, 1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, "l2_store");
      access(0, 1'b1, 1'b0, 1'b0, 32'd1028, 32'h0, "l2_load");
   endtask

   task automatic test_lat0();
      access(1, 1'b0, 1'b1, 1'b0, 32'd1024, 32'h11, "l0_store");
      access(1, 1'b1, 1'b0, 1'b0, 32'd1024, 32'h0, "l0_load");
   endtask

   task automatic test_faults();
      access(0, 1'b0, 1'b1, 1'b0, 32'd1024, 32'hCAFE0000, "f_seed");
      access(0, 1'b0, 1'b1, 1'b0, 32'd1280, 32'h99, "f_st_hi");
      access(0, 1'b1, 1'b0, 1'b0, 32'd1024, 32'h0, "f_reload");
      access(0, 1'b1, 1'b0, 1'b0, 32'd1020, 32'h0, "f_ld_lo");
      access(0, 1'b1, 1'b0, 1'b0, 32'd1026, 32'h0, "f_ld_mis");
      access(0, 1'b1, 1'b0, 1'b0, 32'd1028, 32'h0, "f_ld_ok");
      access(0, 1'b1, 1'b1, 1'b0, 32'd1036, 32'h7, "f_both");
   endtask

   task automatic test_back_to_back();
      access(0, 1'b0, 1'b1, 1'b0, 32'd1044, 32'h0000_1234, "b2b_st");
      access(0, 1'b1, 1'b0, 1'b0, 32'd1044, 32'h0, "b2b_ld");
      access(0, 1'b1, 1'b0, 1'b0, 32'd1028, 32'h0, "b2b_ld2");
   endtask

   task automatic test_mid_reset();
      access(2, 1'b0, 1'b1, 1'b0, 32'd1028, 32'h9, "mr_seed");
      access(2, 1'b1, 1'b0, 1'b0, 32'd1028, 32'h0, "mr_seed_ld");
      access(2, 1'b0, 1'b1, 1'b0, 32'd1036, 32'h77, "mr_old");
      sel = 2; r_en = 1'b0; w_en = 1'b1; addr = 32'd1032; wdata = 32'h5;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
      #1;
      total++;
      if (out_v[2] !== 32'h0 || err_v[2] !== 1'b0)
         $display("FAIL mr_abort: got out=%h err=%b want out=0 err=0",
                  out_v[2], err_v[2]);
      else pass_cnt++;
      @(posedge clk);
      #1;
      rst = 1'b1;
      access(2, 1'b0, 1'b1, 1'b0, 32'd1032, 32'h5, "mr_restart");
      access(2, 1'b1, 1'b0, 1'b0, 32'd1032, 32'h0, "mr_reload");
      sel = 2; r_en = 1'b0; w_en = 1'b1; addr = 32'd1036; wdata = 32'h33;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_reset();
      w_en = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      access(2, 1'b1, 1'b0, 1'b0, 32'd1036, 32'h0, "mr_dropped");
   endtask

`ifdef MEM_STAGE_BYTE_EN
   task automatic test_byte();
      access(0, 1'b0, 1'b1, 1'b0, 32'd1040, 32'h44332211, "by_word_st");
      access(0, 1'b0, 1'b1, 1'b1, 32'd1042, 32'h000000AA, "by_byte_st");
      access(0, 1'b1, 1'b0, 1'b0, 32'd1040, 32'h0, "by_word_ld");
      access(0, 1'b1, 1'b0, 1'b1, 32'd1043, 32'h0, "by_byte_ld");
   endtask
`endif

   initial begin
      wb_en = 1'b0; r_en = 1'b0; w_en = 1'b0; byte_en = 1'b0;
      addr = 32'h0; wdata = 32'h0; dest = 4'h0; sel = 0;
      test_reset();
      test_passthru();
      test_lat2();
      test_lat0();
      test_faults();
      test_back_to_back();
      test_mid_reset();
`ifdef MEM_STAGE_BYTE_EN
      test_byte();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
